// File: rtl/sync_pulse_gen.sv
// Multi-channel sync pulse generator. The period counter drives N_CH delay/width channels.
// Byte-framed configuration is written to shadow registers, which move to the active set only at a wrap or while stopped.
module sync_pulse_gen #(
   parameter int N_CH           = 4,
   parameter int CNT_W          = 32,
   parameter int DEFAULT_PERIOD = 2000000,
   parameter int TIMEOUT        = 100000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_valid,
   input  logic [7:0]      cfg_byte,
   input  logic            trig,
   output logic [N_CH-1:0] pulse,
   output logic            frame_tick,
   output logic            cfg_err,
   output logic            busy
);

   localparam int TO_W = $clog2(TIMEOUT + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_D0,
      S_D1,
      S_D2,
      S_D3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_commit;
   logic             w_abort;
   logic             w_addr_ok;
   logic [TO_W-1:0]  r_to_cnt;
   logic [7:0]       r_addr;
   logic [31:0]      r_data;
   logic             r_wr_pend;
   logic             r_cfg_err;

   logic [CNT_W-1:0] r_sh_period;
   logic [1:0]       r_sh_ctrl;
   logic [CNT_W-1:0] r_sh_dly [N_CH];
   logic [CNT_W-1:0] r_sh_wid [N_CH];
   logic [CNT_W-1:0] r_ac_period;
   logic [1:0]       r_ac_ctrl;
   logic [CNT_W-1:0] r_ac_dly [N_CH];
   logic [CNT_W-1:0] r_ac_wid [N_CH];

   logic [CNT_W-1:0] r_cnt;
   logic             r_trig_run;
   logic             r_frame_tick;
   logic [N_CH-1:0]  r_pulse;
   logic [N_CH-1:0]  w_pulse_nxt;
   logic [CNT_W-1:0] w_period_eff;
   logic             w_running;
   logic             w_wrap;
   logic             w_xfer;

   // ---------------- frame parser ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: if (cfg_valid && cfg_byte == 8'hA5) w_state_nxt = S_ADDR;
         S_ADDR: if (cfg_valid) w_state_nxt = S_D0;
         S_D0:   if (cfg_valid) w_state_nxt = S_D1;
         S_D1:   if (cfg_valid) w_state_nxt = S_D2;
         S_D2:   if (cfg_valid) w_state_nxt = S_D3;
         S_D3: begin
            if (cfg_valid) begin
               w_state_nxt = S_IDLE;
               w_commit    = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // The counter holds the idle cycles already seen; this is the (TIMEOUT+1)-th.
      if (r_state != S_IDLE && !cfg_valid && r_to_cnt == TO_W'(TIMEOUT)) begin
         w_state_nxt = S_IDLE;
         w_abort     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      r_to_cnt <= '0;
      else if (r_state == S_IDLE || cfg_valid || w_abort) r_to_cnt <= '0;
      else                                             r_to_cnt <= r_to_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (cfg_valid) begin
         case (r_state)
            S_ADDR:  r_addr         <= cfg_byte;
            S_D0:    r_data[7:0]    <= cfg_byte;
            S_D1:    r_data[15:8]   <= cfg_byte;
            S_D2:    r_data[23:16]  <= cfg_byte;
            S_D3:    r_data[31:24]  <= cfg_byte;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_addr_ok = (r_addr == 8'h00) || (r_addr == 8'h01);
      for (int ch = 0; ch < N_CH; ch++) begin
         if (r_addr == 8'(16 + 2 * ch) || r_addr == 8'(17 + 2 * ch)) w_addr_ok = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_pend <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_wr_pend <= w_commit && w_addr_ok;
         r_cfg_err <= (w_commit && !w_addr_ok) || w_abort;
      end
   end

   // ---------------- shadow and active registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_period <= CNT_W'(DEFAULT_PERIOD);
         r_sh_ctrl   <= '0;
         for (int ch = 0; ch < N_CH; ch++) begin
            r_sh_dly[ch] <= '0;
            r_sh_wid[ch] <= '0;
         end
      end else if (r_wr_pend) begin
         if (r_addr == 8'h00) r_sh_period <= r_data[CNT_W-1:0];
         if (r_addr == 8'h01) r_sh_ctrl   <= r_data[1:0];
         for (int ch = 0; ch < N_CH; ch++) begin
            if (r_addr == 8'(16 + 2 * ch)) r_sh_dly[ch] <= r_data[CNT_W-1:0];
            if (r_addr == 8'(17 + 2 * ch)) r_sh_wid[ch] <= r_data[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ac_period <= CNT_W'(DEFAULT_PERIOD);
         r_ac_ctrl   <= '0;
         for (int ch = 0; ch < N_CH; ch++) begin
            r_ac_dly[ch] <= '0;
            r_ac_wid[ch] <= '0;
         end
      end else if (w_xfer) begin
         r_ac_period <= r_sh_period;
         r_ac_ctrl   <= r_sh_ctrl;
         for (int ch = 0; ch < N_CH; ch++) begin
            r_ac_dly[ch] <= r_sh_dly[ch];
            r_ac_wid[ch] <= r_sh_wid[ch];
         end
      end
   end

   // ---------------- period counter ----------------
   assign w_period_eff = (r_ac_period < CNT_W'(2)) ? CNT_W'(2) : r_ac_period;
   assign w_running    = r_ac_ctrl[0] && (!r_ac_ctrl[1] || r_trig_run);
   assign w_wrap       = w_running && (r_cnt >= w_period_eff - CNT_W'(1));
   assign w_xfer       = !w_running || w_wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_trig_run   <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         if (!w_running)  r_cnt <= '0;
         else if (w_wrap) r_cnt <= '0;
         else             r_cnt <= r_cnt + CNT_W'(1);
         // A triggered run lasts exactly one period; trig during the run is ignored.
         if (w_wrap)                                               r_trig_run <= 1'b0;
         else if (r_ac_ctrl == 2'b11 && !r_trig_run && trig)       r_trig_run <= 1'b1;
         r_frame_tick <= w_running && (r_cnt == '0);
      end
   end

   // ---------------- channel outputs ----------------
   always_comb begin
      w_pulse_nxt = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         // Subtract instead of adding delay+width so the compare cannot overflow.
         w_pulse_nxt[ch] = w_running && (r_ac_wid[ch] != '0) && (r_cnt >= r_ac_dly[ch]) &&
                           ((r_cnt - r_ac_dly[ch]) < r_ac_wid[ch]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pulse <= '0;
      else        r_pulse <= w_pulse_nxt;
   end

   assign pulse      = r_pulse;
   assign frame_tick = r_frame_tick;
   assign cfg_err    = r_cfg_err;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sync_pulse_gen.sv
// Bench for sync_pulse_gen: directed scenarios plus random frames/trigs against a queue-based model.
module tb_sync_pulse_gen;
   localparam int N_CH  = 4;
   localparam int CNT_W = 32;
   localparam int DEF_P = 20;
   localparam int TMO   = 50;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cfg_valid;
   logic [7:0]      cfg_byte;
   logic            trig;
   logic [N_CH-1:0] pulse;
   logic            frame_tick;
   logic            cfg_err;
   logic            busy;

   always #5 clk = ~clk;

   sync_pulse_gen #(
      .N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(DEF_P), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_byte(cfg_byte), .trig(trig),
      .pulse(pulse), .frame_tick(frame_tick), .cfg_err(cfg_err), .busy(busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int unsigned     sh_period, ac_period, sh_dly[N_CH], sh_wid[N_CH], ac_dly[N_CH], ac_wid[N_CH];
   bit [1:0]        sh_ctrl, ac_ctrl;
   int unsigned     m_cnt;
   bit              m_trun;
   logic [7:0]      frm_q[$];
   int              m_idle;
   bit              pw_vld;
   logic [7:0]      pw_addr;
   int unsigned     pw_data;
   bit [N_CH-1:0]   e_pulse;
   bit              e_tick, e_err;

   task automatic model_reset();
      sh_period = DEF_P; ac_period = DEF_P; sh_ctrl = 0; ac_ctrl = 0;
      for (int c = 0; c < N_CH; c++) begin
         sh_dly[c] = 0; sh_wid[c] = 0; ac_dly[c] = 0; ac_wid[c] = 0;
      end
      m_cnt = 0; m_trun = 0; frm_q.delete(); m_idle = 0; pw_vld = 0;
      e_pulse = '0; e_tick = 0; e_err = 0;
   endtask

   task automatic model_edge(input bit cv, input logic [7:0] cb, input bit tg);
      longint pe;
      bit run, wrap;
      int ch;
      logic [7:0] a;
      pe   = (ac_period < 2) ? 2 : longint'(ac_period);
      run  = ac_ctrl[0] && (!ac_ctrl[1] || m_trun);
      wrap = run && (longint'(m_cnt) == pe - 1);
      for (int c = 0; c < N_CH; c++)
         e_pulse[c] = run && ac_wid[c] != 0 && m_cnt >= ac_dly[c] &&
                      longint'(m_cnt) < longint'(ac_dly[c]) + longint'(ac_wid[c]);
      e_tick = run && m_cnt == 0;
      if (wrap) m_trun = 0;
      else if (ac_ctrl == 2'b11 && !m_trun && tg) m_trun = 1;
      m_cnt = (run && !wrap) ? m_cnt + 1 : 0;
      if (!run || wrap) begin
         ac_period = sh_period; ac_ctrl = sh_ctrl;
         ac_dly = sh_dly; ac_wid = sh_wid;
      end
      if (pw_vld) begin
         if (pw_addr == 8'h00) sh_period = pw_data;
         else if (pw_addr == 8'h01) sh_ctrl = pw_data[1:0];
         else begin
            ch = (int'(pw_addr) - 16) / 2;
            if (pw_addr[0]) sh_wid[ch] = pw_data;
            else            sh_dly[ch] = pw_data;
         end
         pw_vld = 0;
      end
      e_err = 0;
      if (frm_q.size() == 0) begin
         if (cv && cb == 8'hA5) begin frm_q.push_back(cb); m_idle = 0; end
      end else if (cv) begin
         frm_q.push_back(cb);
         m_idle = 0;
         if (frm_q.size() == 6) begin
            a = frm_q[1];
            if (a == 8'h00 || a == 8'h01 || (a >= 8'h10 && int'(a) < 16 + 2 * N_CH)) begin
               pw_vld = 1; pw_addr = a; pw_data = {frm_q[5], frm_q[4], frm_q[3], frm_q[2]};
            end else e_err = 1;
            frm_q.delete();
         end
      end else begin
         m_idle++;
         if (m_idle > TMO) begin frm_q.delete(); e_err = 1; end
      end
   endtask

   // ---------------- stimulus helpers and history ----------------
   bit            h_tick[$];
   bit [N_CH-1:0] h_pulse[$];
   bit            h_err[$];

   task automatic clear_hist();
      h_tick.delete(); h_pulse.delete(); h_err.delete();
   endtask

   task automatic tick(input bit cv, input logic [7:0] cb, input bit tg);
      cfg_valid = cv; cfg_byte = cb; trig = tg;
      @(posedge clk);
      model_edge(cv, cb, tg);
      #1;
      check_val("pulse", 32'(pulse), 32'(e_pulse));
      check_val("frame_tick", 32'(frame_tick), 32'(e_tick));
      check_val("cfg_err", 32'(cfg_err), 32'(e_err));
      check_val("busy", 32'(busy), 32'(frm_q.size() != 0));
      h_tick.push_back(frame_tick); h_pulse.push_back(pulse); h_err.push_back(cfg_err);
      cfg_valid = 1'b0; trig = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'h00, 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] addr, input logic [31:0] data, input int maxgap);
      logic [7:0] b[6];
      b[0] = 8'hA5; b[1] = addr;
      b[2] = data[7:0]; b[3] = data[15:8]; b[4] = data[23:16]; b[5] = data[31:24];
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, b[i], 1'b0);
         if (maxgap > 0) idle($urandom_range(0, maxgap));
      end
   endtask

   function automatic int nth_tick(input int n);
      int seen = 0;
      for (int i = 0; i < h_tick.size(); i++)
         if (h_tick[i]) begin
            if (seen == n) return i;
            seen++;
         end
      return -1000;
   endfunction

   function automatic int count_pulse(input int from, input int len, input int ch);
      int s = 0;
      for (int i = from; i < from + len; i++)
         if (i >= 0 && i < h_pulse.size() && h_pulse[i][ch]) s++;
      return s;
   endfunction

   function automatic int first_high(input int from, input int ch);
      for (int i = (from < 0 ? 0 : from); i < h_pulse.size(); i++)
         if (h_pulse[i][ch]) return i;
      return -1000;
   endfunction

   function automatic int count_bits(input bit q[$]);
      int s = 0;
      foreach (q[i]) s += int'(q[i]);
      return s;
   endfunction

   function automatic int first_bit(input bit q[$]);
      foreach (q[i]) if (q[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] rand_addr();
      int unsigned r = $urandom_range(0, 9);
      if (r == 0) return 8'h00;
      if (r == 1) return 8'h01;
      if (r <= 7) return 8'(16 + $urandom_range(0, 2 * N_CH - 1));
      if (r == 8) return 8'($urandom_range(2, 15));
      return 8'h7F;
   endfunction

   function automatic logic [31:0] rand_data(input logic [7:0] addr);
      if (addr == 8'h00) return 32'($urandom_range(0, 25));
      if (addr == 8'h01) return ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) return $urandom;
      return 32'($urandom_range(0, 30));
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      int t0, t1, t2, k;
      logic [7:0] a, jb;
      int unsigned sel;
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_byte = 8'h00; trig = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_pulse", 32'(pulse), 0);
      check_val("rst_tick", 32'(frame_tick), 0);
      check_val("rst_err", 32'(cfg_err), 0);
      check_val("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;

      // idle after reset
      clear_hist();
      idle(3 * DEF_P);
      check_val("t1_no_tick", 32'(count_bits(h_tick)), 0);
      check_val("t1_no_pulse", 32'(count_pulse(0, h_pulse.size(), 0)), 0);

      // basic free-run configuration
      send_frame(8'h00, 10, 0);
      send_frame(8'h10, 2, 0);
      send_frame(8'h11, 3, 0);
      send_frame(8'h01, 1, 0);
      idle(5);
      clear_hist();
      idle(40);
      t0 = nth_tick(0); t1 = nth_tick(1); t2 = nth_tick(2);
      check_val("t2_period_a", 32'(t1 - t0), 10);
      check_val("t2_period_b", 32'(t2 - t1), 10);
      check_val("t2_width", 32'(count_pulse(t0, 10, 0)), 3);
      check_val("t2_rise", 32'(first_high(t0, 0) - t0), 2);

      // truncation at wrap and delay beyond period
      send_frame(8'h12, 8, 0);
      send_frame(8'h13, 5, 0);
      send_frame(8'h14, 12, 0);
      send_frame(8'h15, 3, 0);
      idle(25);
      clear_hist();
      idle(30);
      t0 = nth_tick(0);
      check_val("t3_ch1_width", 32'(count_pulse(t0, 10, 1)), 2);
      check_val("t3_ch2_quiet", 32'(count_pulse(0, h_pulse.size(), 2)), 0);

      // width change mid-period applies from the next period
      clear_hist();
      k = 0;
      do begin tick(1'b0, 8'h00, 1'b0); k++; end while (!frame_tick && k < 40);
      check_val("t4_wait_tick", 32'(frame_tick), 1);
      send_frame(8'h11, 6, 0);
      idle(25);
      t0 = nth_tick(0); t1 = nth_tick(1);
      check_val("t4_cur_width", 32'(count_pulse(t0, 10, 0)), 3);
      check_val("t4_next_width", 32'(count_pulse(t1, 10, 0)), 6);

      // bad address, timeout abort, recovery
      clear_hist();
      send_frame(8'h7F, 32'h0000_1234, 0);
      idle(3);
      check_val("t5_bad_err", 32'(count_bits(h_err)), 1);
      clear_hist();
      tick(1'b1, 8'hA5, 1'b0);
      tick(1'b1, 8'h00, 1'b0);
      idle(TMO + 3);
      check_val("t5_tmo_err", 32'(count_bits(h_err)), 1);
      check_val("t5_tmo_when", 32'(first_bit(h_err)), 32'(TMO + 2));
      check_val("t5_tmo_busy", 32'(busy), 0);
      send_frame(8'h00, 12, 2);
      idle(40);
      clear_hist();
      idle(30);
      t0 = nth_tick(0); t1 = nth_tick(1);
      check_val("t5_new_period", 32'(t1 - t0), 12);

      // triggered mode
      send_frame(8'h01, 3, 0);
      idle(30);
      clear_hist();
      idle(20);
      check_val("t6_idle_ticks", 32'(count_bits(h_tick)), 0);
      check_val("t6_idle_pulse", 32'(count_pulse(0, h_pulse.size(), 0)), 0);
      clear_hist();
      tick(1'b0, 8'h00, 1'b1);
      idle(5);
      tick(1'b0, 8'h00, 1'b1);
      idle(30);
      check_val("t6_one_period", 32'(count_bits(h_tick)), 1);
      check_val("t6_ch0_width", 32'(count_pulse(0, h_pulse.size(), 0)), 6);

      // asynchronous reset in the middle of a pulse
      tick(1'b0, 8'h00, 1'b1);
      k = 0;
      while (!pulse[0] && k < 30) begin tick(1'b0, 8'h00, 1'b0); k++; end
      check_val("t6_wait_pulse", 32'(pulse[0]), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t6_async_pulse", 32'(pulse), 0);
      model_reset();
      @(posedge clk); @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3 * DEF_P);

      // reset in the middle of a frame discards it
      tick(1'b1, 8'hA5, 1'b0);
      tick(1'b1, 8'h00, 1'b0);
      tick(1'b1, 8'h07, 1'b0);
      rst_n = 1'b0;
      #1;
      check_val("rst_mid_frame_busy", 32'(busy), 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(1'b1, 8'h00, 1'b0);
      tick(1'b1, 8'h00, 1'b0);
      tick(1'b1, 8'h00, 1'b0);
      idle(5);

      // random traffic
      for (int it = 0; it < 250; it++) begin
         sel = $urandom_range(0, 99);
         if (sel < 45) begin
            a = rand_addr();
            send_frame(a, rand_data(a), 3);
         end else if (sel < 75) begin
            idle($urandom_range(1, 25));
         end else if (sel < 88) begin
            tick(1'b0, 8'h00, 1'b1);
            idle($urandom_range(0, 8));
         end else if (sel < 95) begin
            jb = 8'($urandom_range(0, 255));
            if (jb == 8'hA5) jb = 8'h5A;
            tick(1'b1, jb, 1'b0);
         end else begin
            tick(1'b1, 8'hA5, 1'b0);
            repeat ($urandom_range(0, 4)) tick(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            idle(TMO + 2);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
